// File: rtl/booth_arbiter.sv
// rtl/booth_arbiter.sv - round-robin arbiter in front of a shared signed 4x4 radix-2 Booth multiplier
module booth_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic       req0,
    input  logic [3:0] a0,
    input  logic [3:0] b0,
    input  logic       req1,
    input  logic [3:0] a1,
    input  logic [3:0] b1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       busy,
    output logic       done,
    output logic       done_id,
    output logic [7:0] result
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     state;
    state_t     state_next;

    // Round-robin pointer: the requester granted most recently loses the next tie.
    logic       last_id;

    // Booth datapath; A and M carry one extra sign bit so that M = -8 negates cleanly.
    logic [4:0] m_reg;
    logic [4:0] acc;
    logic [3:0] q_reg;
    logic       q_m1;
    logic [1:0] step;
    logic       owner_id;

    logic       gnt0_q;
    logic       gnt1_q;
    logic [7:0] result_q;
    logic       done_id_q;

    logic       any_req;
    logic       win_id;
    logic [3:0] win_a;
    logic [3:0] win_b;

    logic [4:0] sum;
    logic [4:0] acc_sh;
    logic [3:0] q_sh;
    logic       q_m1_sh;

    // Pick the winner: a lone requester wins outright, a tie goes to the one not served last.
    always_comb begin
        any_req = req0 | req1;
        win_id  = 1'b0;
        if (req0 && req1) begin
            win_id = ~last_id;
        end else if (req1) begin
            win_id = 1'b1;
        end
        win_a = win_id ? a1 : a0;
        win_b = win_id ? b1 : b0;
    end

    // One Booth iteration: conditional add/subtract of M, then arithmetic shift of {A,Q,Q_1}.
    always_comb begin
        sum = acc;
        case ({q_reg[0], q_m1})
            2'b01:   sum = acc + m_reg;
            2'b10:   sum = acc - m_reg;
            default: sum = acc;
        endcase
        acc_sh  = {sum[4], sum[4:1]};
        q_sh    = {sum[0], q_reg[3:1]};
        q_m1_sh = q_reg[0];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept only from IDLE, four CALC cycles, one DONE cycle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (any_req) state_next = S_CALC;
            S_CALC:  if (step == 2'd3) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // Operand capture, grant pulses, Booth iterations and result registration.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_id   <= 1'b1;
            gnt0_q    <= 1'b0;
            gnt1_q    <= 1'b0;
            m_reg     <= 5'd0;
            acc       <= 5'd0;
            q_reg     <= 4'd0;
            q_m1      <= 1'b0;
            step      <= 2'd0;
            owner_id  <= 1'b0;
            result_q  <= 8'h00;
            done_id_q <= 1'b0;
        end else begin
            gnt0_q <= 1'b0;
            gnt1_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (any_req) begin
                        m_reg    <= {win_a[3], win_a};
                        acc      <= 5'd0;
                        q_reg    <= win_b;
                        q_m1     <= 1'b0;
                        step     <= 2'd0;
                        owner_id <= win_id;
                        last_id  <= win_id;
                        gnt0_q   <= ~win_id;
                        gnt1_q   <= win_id;
                    end
                end
                S_CALC: begin
                    acc   <= acc_sh;
                    q_reg <= q_sh;
                    q_m1  <= q_m1_sh;
                    step  <= step + 2'd1;
                    if (step == 2'd3) begin
                        result_q  <= {acc_sh[3:0], q_sh};
                        done_id_q <= owner_id;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Outputs derived from state and registered datapath values.
    always_comb begin
        gnt0    = gnt0_q;
        gnt1    = gnt1_q;
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        done_id = done_id_q;
        result  = result_q;
    end

endmodule
